// File: rtl/bk_seq_pkg.sv
// bk_seq_pkg: shared definitions for the serial Brent-Kung wide adder.
//   NIB_W      - width of one adder slice (a nibble)
//   state_t    - sequencer state encoding (StIdle, StRun, StDone)
//   clog2_min1 - counter width helper that never returns zero
package bk_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // A one-nibble operand still needs a 1-bit counter.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/brent_kung_cin.sv
// brent_kung_cin: 4-bit Brent-Kung adder with carry-in, purely combinational.
//   a, b  - 4-bit addends
//   cin   - carry into bit 0
//   sum   - 4-bit sum
//   cout  - carry out of bit 3
module brent_kung_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       g10, p10, g32, p32, g30, p30;
  logic       c1, c2, c3, c4;

  always_comb begin
    g   = a & b;
    p   = a ^ b;
    // Up-sweep: pairwise group generate/propagate, then the full 4-bit group.
    g10 = g[1] | (p[1] & g[0]);
    p10 = p[1] & p[0];
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];
    g30 = g32 | (p32 & g10);
    p30 = p32 & p10;
    // Down-sweep: cin folded in as the generate of position -1.
    c1   = g[0] | (p[0] & cin);
    c2   = g10 | (p10 & cin);
    c3   = g[2] | (p[2] & c2);
    c4   = g30 | (p30 & cin);
    sum  = p ^ {c3, c2, c1, cin};
    cout = c4;
  end

endmodule

// File: rtl/bk_serial_add_seq.sv
// bk_serial_add_seq: wide adder (4*NIB bits) built from one 4-bit Brent-Kung slice
// reused once per clock, least significant nibble first.
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid, in_ready  - operand handshake (ready only when idle)
//   a, b, cin           - operands and carry into nibble 0
//   sub                 - only with BK_SEQ_SUB_EN defined: compute a - b
//   out_valid/out_ready - result handshake; result held while out_ready is low
//   sum, cout           - result, zero whenever out_valid is low
// Optional feature macro: BK_SEQ_SUB_EN.
module bk_serial_add_seq
  import bk_seq_pkg::*;
#(
  parameter int unsigned NIB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic             cin,
`ifdef BK_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*NIB-1:0] sum,
  output logic             cout
);

  localparam int unsigned W       = NIB_W * NIB;
  localparam int unsigned CntW    = clog2_min1(NIB);
  localparam logic [CntW-1:0] CntLast = CntW'(NIB - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    sum_sh_q, sum_sh_d;

  logic [W-1:0]     b_load;
  logic             c_load;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_cout;

`ifdef BK_SEQ_SUB_EN
  // a - b as a + ~b + 1: invert B once at load and force the initial carry.
  assign b_load = sub ? ~b : b;
  assign c_load = sub | cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  brent_kung_cin u_slice (
    .a    (a_sh_q[NIB_W-1:0]),
    .b    (b_sh_q[NIB_W-1:0]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = c_load;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // New nibble enters at the top; after NIB steps it has reached its slot.
        sum_sh_d = (sum_sh_q >> NIB_W) | (W'(nib_sum) << (W - NIB_W));
        a_sh_d   = a_sh_q >> NIB_W;
        b_sh_d   = b_sh_q >> NIB_W;
        carry_d  = nib_cout;
        count_d  = count_q + 1'b1;
        if (count_q == CntLast) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
    end
  end

  // Partial sums and stale results stay hidden outside DONE.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = out_valid ? sum_sh_q : '0;
  assign cout      = out_valid & carry_q;

endmodule

// File: tb/tb_bk_serial_add_seq.sv
// tb_bk_serial_add_seq: scoreboard bench for bk_serial_add_seq. Two instances
// (NIB=4 and NIB=1) run independently; expected results are pushed at accept and
// popped by per-instance monitors when a result is handed off.
`timescale 1ns/1ps
module tb_bk_serial_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // NIB = 4 instance
  logic        rst_n4, iv4, ir4, cin4, ov4, or4, cout4;
  logic [15:0] a4, b4, sum4;
  logic        bp_en;
  logic [64:0] q4[$];

  // NIB = 1 instance
  logic        rst_n1, iv1, ir1, cin1, ov1, or1, cout1;
  logic [3:0]  a1, b1, sum1;
  logic        done1;
  logic [64:0] q1[$];

`ifdef BK_SEQ_SUB_EN
  logic sub4, sub1;
`endif

  bk_serial_add_seq #(.NIB(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n4),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
`ifdef BK_SEQ_SUB_EN
    .sub       (sub4),
`endif
    .out_valid (ov4),
    .out_ready (or4),
    .sum       (sum4),
    .cout      (cout4)
  );

  bk_serial_add_seq #(.NIB(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n1),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
`ifdef BK_SEQ_SUB_EN
    .sub       (sub1),
`endif
    .out_valid (ov1),
    .out_ready (or1),
    .sum       (sum1),
    .cout      (cout1)
  );

  // Reference: {cout, sum} for a w-bit add (a+b+c) or subtract (a-b, cout = no borrow).
  function automatic logic [64:0] model(input int unsigned w, input logic [63:0] a,
                                        input logic [63:0] b, input logic c, input logic s);
    logic [64:0] full, res;
    logic [63:0] mask;
    logic        co;
    mask = (64'd1 << w) - 64'd1;
    if (s) begin
      res = 65'((a - b) & mask);
      co  = (a >= b);
    end else begin
      full = 65'(a) + 65'(b) + 65'(c);
      res  = full & 65'(mask);
      co   = full[w];
    end
    res[w] = co;
    return res;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- NIB = 4 driver helpers ----------------
  task automatic issue4(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (!ir4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir4) begin
      check("issue4_ready_timeout", 65'(ir4), 65'd1);
      return;
    end
    iv4 = 1'b1; a4 = a; b4 = b; cin4 = c;
`ifdef BK_SEQ_SUB_EN
    sub4 = s;
`endif
    @(posedge clk);
    q4.push_back(model(16, 64'(a), 64'(b), c, s));
    #1 iv4 = 1'b0;
  endtask

  task automatic await4(input string name, input logic [16:0] exp);
    int n;
    n = 0;
    while (!ov4 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ov4) check({name, "_timeout"}, 65'(ov4), 65'd1);
    else check(name, 65'({cout4, sum4}), 65'(exp));
  endtask

  task automatic drain4();
    int n;
    n = 0;
    while (q4.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (q4.size() != 0) check("drain4_timeout", 65'(q4.size()), 65'd0);
    #1;
  endtask

  // ---------------- NIB = 1 driver helpers ----------------
  task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (!ir1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir1) begin
      check("issue1_ready_timeout", 65'(ir1), 65'd1);
      return;
    end
    iv1 = 1'b1; a1 = a; b1 = b; cin1 = c;
`ifdef BK_SEQ_SUB_EN
    sub1 = s;
`endif
    @(posedge clk);
    q1.push_back(model(4, 64'(a), 64'(b), c, s));
    #1 iv1 = 1'b0;
  endtask

  task automatic drain1();
    int n;
    n = 0;
    while (q1.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (q1.size() != 0) check("drain1_timeout", 65'(q1.size()), 65'd0);
    #1;
  endtask

  // ---------------- Monitors ----------------
  always @(negedge clk) begin
    if (rst_n4 === 1'b1) begin
      if (ov4) begin
        check("busy_in_ready4", 65'(ir4), 65'd0);
        if (q4.size() == 0) check("unexpected_result4", 65'(ov4), 65'd0);
        else if (or4) check("result4", 65'({cout4, sum4}), q4.pop_front());
      end else begin
        check("outputs_zero4", 65'({cout4, sum4}), 65'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n1 === 1'b1) begin
      if (ov1) begin
        check("busy_in_ready1", 65'(ir1), 65'd0);
        if (q1.size() == 0) check("unexpected_result1", 65'(ov1), 65'd0);
        else if (or1) check("result1", 65'({cout1, sum1}), q1.pop_front());
      end else begin
        check("outputs_zero1", 65'({cout1, sum1}), 65'd0);
      end
    end
  end

  // Random sink backpressure for the NIB = 4 stream.
  always @(posedge clk) begin
    if (bp_en) #1 or4 = ($urandom_range(0, 3) != 0);
  end

  // ---------------- NIB = 4 sequence ----------------
  initial begin
    int          lat, n;
    logic [15:0] ra, rb;
    logic        rc, rs;
    iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; or4 = 1'b1; bp_en = 1'b0;
`ifdef BK_SEQ_SUB_EN
    sub4 = 1'b0;
`endif
    rst_n4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 65'(ir4), 65'd1);
    check("reset_out_valid", 65'(ov4), 65'd0);
    check("reset_sum_cout", 65'({cout4, sum4}), 65'd0);
    @(negedge clk) rst_n4 = 1'b1;

    // Latency and basic add
    issue4(16'h1234, 16'h4321, 1'b0, 1'b0);
    lat = 0;
    while (!ov4 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency4", 65'(lat), 65'd4);
    check("add_1234_4321", 65'({cout4, sum4}), 65'h05555);
    drain4();

    // Full carry ripple
    issue4(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    await4("add_ffff_0001", 17'h10000);
    drain4();
    issue4(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    await4("add_ffff_ffff_c1", 17'h1FFFF);
    drain4();

    // Backpressure: result held for three cycles
    or4 = 1'b0;
    issue4(16'h0ABC, 16'h0F0F, 1'b1, 1'b0);
    await4("bp_result", 17'h019CC);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid_held", 65'(ov4), 65'd1);
      check("bp_result_held", 65'({cout4, sum4}), 65'h019CC);
      check("bp_in_ready_low", 65'(ir4), 65'd0);
    end
    or4 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 65'(ov4), 65'd0);
    check("bp_release_ready", 65'(ir4), 65'd1);

    // Reset after two nibbles
    issue4(16'h1234, 16'h1111, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n4 = 1'b0;
    q4.delete();
    @(posedge clk);
    #1;
    check("abort_out_valid", 65'(ov4), 65'd0);
    check("abort_sum", 65'({cout4, sum4}), 65'd0);
    check("abort_in_ready", 65'(ir4), 65'd1);
    rst_n4 = 1'b1;
    issue4(16'h0010, 16'h0020, 1'b0, 1'b0);
    await4("post_abort_add", 17'h00030);
    drain4();

`ifdef BK_SEQ_SUB_EN
    issue4(16'h0005, 16'h0007, 1'b0, 1'b1);
    await4("sub_5_7", 17'h0FFFE);
    drain4();
    issue4(16'h0007, 16'h0005, 1'b0, 1'b1);
    await4("sub_7_5", 17'h10002);
    drain4();
`endif

    // Random stream with random sink backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef BK_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      issue4(ra, rb, rc, rs);
    end
    bp_en = 1'b0;
    @(posedge clk);
    #2 or4 = 1'b1;
    drain4();

    n = 0;
    while (!done1 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("stream1_done", 65'(done1), 65'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- NIB = 1 sequence ----------------
  initial begin
    int         lat;
    logic [3:0] ra, rb;
    logic       rc, rs;
    iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; or1 = 1'b1; done1 = 1'b0;
`ifdef BK_SEQ_SUB_EN
    sub1 = 1'b0;
`endif
    rst_n1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n1 = 1'b1;

    issue1(4'hF, 4'h1, 1'b0, 1'b0);
    lat = 0;
    while (!ov1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency1", 65'(lat), 65'd1);
    check("nib1_add_f_1", 65'({cout1, sum1}), 65'h10);
    drain1();

    // Back-to-back random stream
    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef BK_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      issue1(ra, rb, rc, rs);
    end
    drain1();
    done1 = 1'b1;
  end

endmodule
